// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, port indices and response tag type for mem_arbiter
//
// Contents:
//   MEM_ADDR      : word-address width of the data memory (64k words)
//   LEN_REG       : data word width
//   MEM_PORT_CORE : port index of the execute-stage load/store path
//   MEM_PORT_HOST : port index of the host/debug loader
//   resp_tag_t    : load tag carried alongside the command stage
package mem_arbiter_pkg;

  localparam int MEM_ADDR = 16;
  localparam int LEN_REG  = 32;

  localparam logic MEM_PORT_CORE = 1'b0;
  localparam logic MEM_PORT_HOST = 1'b1;

  typedef struct packed {
    logic valid;  // command stage holds a load
    logic port;   // port the load data belongs to
  } resp_tag_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - grant selection between the core port and the host port
//
// Config macro: VENUS_MEM_ARB_RR_EN selects round-robin; otherwise fixed
// priority to port 0 with a starvation counter for port 1.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   valid[1:0] : request valid per port (bit index = port index)
//   grant[1:0] : one-hot (or zero) grant; a grant bit implies its valid bit
module mem_arb_pick
  import mem_arbiter_pkg::*;
`ifndef VENUS_MEM_ARB_RR_EN
#(
  parameter int MAX_WAIT = 15
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

`ifdef VENUS_MEM_ARB_RR_EN

  // Port favoured on the next contention. Reset favours the core port, after
  // that it always points at the port that was not granted most recently.
  logic prio;

  always_comb begin
    grant = valid;
    if (valid[MEM_PORT_CORE] && valid[MEM_PORT_HOST]) begin
      grant = prio ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= MEM_PORT_CORE;
    end else if (grant[MEM_PORT_HOST]) begin
      prio <= MEM_PORT_CORE;
    end else if (grant[MEM_PORT_CORE]) begin
      prio <= MEM_PORT_HOST;
    end
  end

`else

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;
  logic       starved;

  assign starved = (wait_cnt == WAIT_LIM);

  // Host wins when alone, or when it has been denied long enough.
  always_comb begin
    grant = 2'b00;
    if (valid[MEM_PORT_HOST] && (!valid[MEM_PORT_CORE] || starved)) begin
      grant[MEM_PORT_HOST] = 1'b1;
    end else if (valid[MEM_PORT_CORE]) begin
      grant[MEM_PORT_CORE] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (grant[MEM_PORT_HOST]) begin
      wait_cnt <= 8'd0;
    end else if (valid[MEM_PORT_HOST] && !starved) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of the single-port data memory
//
// Config macro: VENUS_MEM_ARB_RR_EN (round-robin arbitration when defined).
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req0_*, resp0_*      : core load/store port (valid/we/addr/wdata, ready; resp valid/rdata)
//   req1_*, resp1_*      : host/debug loader port, same set
//   mem_A, mem_W, mem_D  : registered command to the memory
//   mem_Q                : memory read data, valid the cycle after the memory edge
//
// Load data appears on respN_rdata two edges after acceptance; only the port
// whose resp_valid is high owns that cycle's data.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_ADDR = mem_arbiter_pkg::MEM_ADDR,
  parameter int LEN_REG  = mem_arbiter_pkg::LEN_REG,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic                req0_we,
  input  logic [MEM_ADDR-1:0] req0_addr,
  input  logic [LEN_REG-1:0]  req0_wdata,
  output logic                req0_ready,
  output logic                resp0_valid,
  output logic [LEN_REG-1:0]  resp0_rdata,
  input  logic                req1_valid,
  input  logic                req1_we,
  input  logic [MEM_ADDR-1:0] req1_addr,
  input  logic [LEN_REG-1:0]  req1_wdata,
  output logic                req1_ready,
  output logic                resp1_valid,
  output logic [LEN_REG-1:0]  resp1_rdata,
  output logic [MEM_ADDR-1:0] mem_A,
  output logic                mem_W,
  output logic [LEN_REG-1:0]  mem_D,
  input  logic [LEN_REG-1:0]  mem_Q
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_range
    $error("mem_arbiter: MAX_WAIT must be within 1..255");
  end

  logic [1:0] grant;

`ifdef VENUS_MEM_ARB_RR_EN
  mem_arb_pick u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );
`else
  mem_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );
`endif

  assign req0_ready = grant[MEM_PORT_CORE];
  assign req1_ready = grant[MEM_PORT_HOST];

  // Winning request, muxed ahead of the command registers.
  logic                accept;
  logic                sel_host;
  logic                win_we;
  logic [MEM_ADDR-1:0] win_addr;
  logic [LEN_REG-1:0]  win_wdata;

  assign accept    = |grant;
  assign sel_host  = grant[MEM_PORT_HOST];
  assign win_we    = sel_host ? req1_we    : req0_we;
  assign win_addr  = sel_host ? req1_addr  : req0_addr;
  assign win_wdata = sel_host ? req1_wdata : req0_wdata;

  resp_tag_t tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_A       <= '0;
      mem_W       <= 1'b0;
      mem_D       <= '0;
      tag         <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      // Command stage: address/data hold through idle cycles, write strobe does not.
      mem_W <= accept && win_we;
      if (accept) begin
        mem_A <= win_addr;
        mem_D <= win_wdata;
      end
      tag.valid <= accept && !win_we;
      tag.port  <= sel_host;
      // Response stage lines up with mem_Q for the load issued one edge earlier.
      resp0_valid <= tag.valid && (tag.port == MEM_PORT_CORE);
      resp1_valid <= tag.valid && (tag.port == MEM_PORT_HOST);
    end
  end

  assign resp0_rdata = mem_Q;
  assign resp1_rdata = mem_Q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port data memory `mem32x64k` between two requesters: port 0, the execute-stage load/store path, and port 1, the host/debug loader. It arbitrates one access per cycle and registers the winning command onto the memory pins. For reads it returns data to the originating port with a fixed latency. Without it, only the core can reach data memory.

## Interface
Parameters:
- `MEM_ADDR`, 16: word-address width (64k words).
- `LEN_REG`, 32: data width.
- `MAX_WAIT`, 15: cycles port 1 may be denied before it is forced ahead; legal range 1..255.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req0_valid`  in  1: port 0 request.
- `req0_we`  in  1: 1 = store, 0 = load.
- `req0_addr`  in  MEM_ADDR: word address.
- `req0_wdata`  in  LEN_REG: store data.
- `req0_ready`  out  1: request accepted this cycle.
- `resp0_valid`  out  1: load data valid.
- `resp0_rdata`  out  LEN_REG: load data.
- `req1_*`, `resp1_*`: identical set for port 1.
- `mem_A`  out  MEM_ADDR: to memory `A`.
- `mem_W`  out  1: to memory `W`.
- `mem_D`  out  LEN_REG: to memory `D`.
- `mem_Q`  in  LEN_REG: from memory `Q`, valid the cycle after the memory edge.

## Operation
- **Handshake.** A request transfers on a rising edge where `valid && ready`.
  - `ready` is combinational from both `valid` inputs and the arbitration state.
  - At most one `ready` is high per cycle.
  - `ready` is never high without the matching `valid`.
  - Requesters must hold `valid`, `we`, `addr` and `wdata` stable until accepted.
- **Default arbitration.** Port 0 has fixed priority.
  - An 8-bit `wait_cnt` increments each cycle that `req1_valid && !req1_ready`, saturating at `MAX_WAIT`.
  - When `wait_cnt == MAX_WAIT`, port 1 wins over port 0.
  - `wait_cnt` clears on a port 1 acceptance.
- **Command stage.** The accepted request is registered into `mem_A`, `mem_W`, `mem_D`.
  - `mem_W` is high for exactly one cycle per store.
  - In idle cycles, `mem_W` = 0 and `mem_A`/`mem_D` hold their last value.
- **Response stage.** For a load, a tag (valid, port) is pipelined alongside the command.
  - One cycle after the command stage, the tagged port's `resp_valid` is asserted for exactly one cycle.
  - Both `resp_rdata` outputs are wired to `mem_Q`. Only the port whose `resp_valid` is high treats it as data.
  - Stores produce no response.
- **Ordering.** Accesses hit memory in acceptance order. A load accepted in the cycle after a store to the same address returns the stored data.
- **Addresses.** Address arithmetic is the requester's job. Addresses are used unsigned, and wrap at `2^MEM_ADDR` by truncation upstream.

## Timing
- Request accepted at edge E0. `mem_*` are driven during E0..E1, and the memory samples at E1.
- Load: `resp_valid` is high and `mem_Q` valid during E1..E2. That is 2 cycles from acceptance to data.
- Throughput: one access per cycle total, loads and stores freely interleaved, no bubbles.
- Reset, asserted asynchronously:
  - Outputs: `mem_W` = 0, `mem_A` = 0, `mem_D` = 0, `resp0_valid` = 0, `resp1_valid` = 0.
  - Internal state: `wait_cnt` = 0, response tag cleared, round-robin pointer = port 0.
  - `req*_ready` follows the combinational rule, so it is 0 while both `valid` are 0.
  - In-flight loads are dropped: no `resp_valid` appears after reset deasserts.
  - A store whose `mem_W` pulse was cut by reset is lost.
- Simultaneous valids, default mode: port 0 wins unless `wait_cnt == MAX_WAIT`.
- Port 1 alone is accepted immediately, regardless of `wait_cnt`.

## Configuration
- `VENUS_MEM_ARB_RR_EN` defined:
  - Arbitration is round-robin using a 1-bit last-grant pointer.
  - On contention, the port not granted most recently wins.
  - `wait_cnt` and `MAX_WAIT` have no effect; the counter is not built.
- Undefined: fixed priority with the starvation counter, as described under Operation.
- Handshake, latency and reset behaviour are identical in both modes.

## Structure
- Shared package/include (`defs_insn.v` set):
  - `MEM_ADDR`, `LEN_REG`.
  - Port-index constants `MEM_PORT_CORE` = 0 and `MEM_PORT_HOST` = 1.
- One sub-module, `mem_arb_pick`: combinational grant logic plus `wait_cnt` or the round-robin pointer. It outputs `grant[1:0]`.
- The top level holds the command registers and the response tag pipeline.

## Test plan
1. Reset mid-load:
   - Stimulus: port 0 loads addr 0x0010; `rst_n` pulses low during the E1 cycle.
   - Response: no `resp0_valid`; `mem_W` = 0 and `mem_A` = 0 while reset is low.
2. Store then load:
   - Stimulus: port 0 stores 0xDEADBEEF to 0x1234, then loads 0x1234 on the next cycle.
   - Response: `resp0_valid` two cycles after the load is accepted, with `resp0_rdata` = 0xDEADBEEF.
3. Back-to-back contention, default mode, `MAX_WAIT` = 3:
   - Stimulus: both ports hold `valid` continuously.
   - Response: port 0 is granted 3 cycles, port 1 on the 4th, and the pattern repeats.
4. Same stimulus with `VENUS_MEM_ARB_RR_EN` defined:
   - Response: grants alternate 0,1,0,1, with port 0 first after reset.
5. Interleaved loads:
   - Stimulus: port 1 loads 0x0001 at E0 and port 0 loads 0x0002 at E1 (memory preloaded with 0xA1 and 0xA2).
   - Response: `resp1_valid` with 0xA1 at E2, `resp0_valid` with 0xA2 at E3; never both in the same cycle.
6. Port 1 alone, with port 0 idle:
   - Stimulus: port 1 stores 0x0 to 0xFFFF.
   - Response: `req1_ready` the same cycle; `mem_W` high for exactly one cycle with `mem_A` = 0xFFFF.
